// File: rtl/calc_pkg.sv
// Shared types and constants for the serial subtractor calculator.
package calc_pkg;

  localparam int unsigned CALC_WIDTH       = 4;
  localparam int unsigned CALC_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    SHOW   = 2'd3
  } calc_state_t;

  // One full-subtractor step: difference bit for a - b - br.
  function automatic logic sub_diff(input logic a, input logic b, input logic br);
    return a ^ b ^ br;
  endfunction

  // One full-subtractor step: borrow out of a - b - br.
  function automatic logic sub_borrow(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Synchronizes one active-low push-button and emits a one-cycle pulse on
// each synchronized press (1->0 transition).
module key_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Flops rest at 1 (button released) so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(key_n);
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press_c = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/calc_four_bit_subtractor.sv
// Push-button driven serial (bit-per-cycle) subtractor computing A-B.
// Optional macro CALC_SUB_ABS_DISPLAY_EN shows |A-B| in SHOW instead of the raw difference.
module calc_four_bit_subtractor
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH       = CALC_WIDTH,
  parameter int unsigned SYNC_STAGES = CALC_SYNC_STAGES
) (
  input  logic             CLOCK_50,
  input  logic             RST,
  input  logic [1:0]       KEY,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] LED,
  output logic             BORROW,
  output logic             DONE
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic enter_c;
  logic clear_c;

  key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_enter (
    .clk     (CLOCK_50),
    .rst     (RST),
    .key_n   (KEY[0]),
    .press_c (enter_c)
  );

  key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_clear (
    .clk     (CLOCK_50),
    .rst     (RST),
    .key_n   (KEY[1]),
    .press_c (clear_c)
  );

  calc_state_t      state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] led_d;
  logic             done_d;
  logic             borrow_d;
  logic             bit_a, bit_b;
  logic [WIDTH-1:0] show_val;

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      LED     <= '0;
      DONE    <= 1'b0;
      BORROW  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      LED     <= led_d;
      DONE    <= done_d;
      BORROW  <= borrow_d;
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    led_d    = '0;
    done_d   = 1'b0;
    borrow_d = 1'b0;
    show_val = '0;
    bit_a    = a_q[cnt_q];
    bit_b    = b_q[cnt_q];

    if (clear_c) begin
      // Clear wins over a coincident enter.
      state_d = LOAD_A;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      br_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (enter_c) begin
            a_d     = SW;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (enter_c) begin
            b_d     = SW;
            br_d    = 1'b0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          // Difference bits shift in from the top, so after WIDTH steps bit 0 is the LSB.
          res_d = {sub_diff(bit_a, bit_b, br_q), res_q[WIDTH-1:1]};
          br_d  = sub_borrow(bit_a, bit_b, br_q);
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (enter_c) begin
            a_d     = SW;
            state_d = LOAD_B;
          end
        end
        default: state_d = LOAD_A;
      endcase
    end

`ifdef CALC_SUB_ABS_DISPLAY_EN
    show_val = br_d ? WIDTH'(~res_d + WIDTH'(1)) : res_d;
`else
    show_val = res_d;
`endif

    case (state_d)
      LOAD_B:  led_d = a_d;
      SHOW:    led_d = show_val;
      default: led_d = '0;
    endcase

    // DONE rises on the second SHOW cycle and drops on the edge that leaves SHOW.
    done_d   = (state_q == SHOW) && (state_d == SHOW);
    borrow_d = done_d & br_d;
  end

endmodule

// File: doc/calc_four_bit_subtractor.md
CALC_FOUR_BIT_SUBTRACTOR -- requirements
Module: calc_four_bit_subtractor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter WIDTH, default 4, SHALL set the operand and result width in bits.
REQ-003 Parameter SYNC_STAGES, default 2, SHALL set the flip-flop depth of the key synchronizer.
REQ-004 CLOCK_50  in  1  SHALL be the system clock; all state changes on its rising edge.
REQ-005 RST  in  1  SHALL be the reset, asynchronous and active-high.
REQ-006 KEY  in  2  SHALL be the active-low push-buttons: KEY[0] = enter, KEY[1] = clear; both asynchronous to CLOCK_50.
REQ-007 SW  in  WIDTH  SHALL be the operand switches.
REQ-008 LED  out  WIDTH  SHALL be the display: stored A or the result.
REQ-009 BORROW  out  1  SHALL be the final borrow of A-B (1 when A<B unsigned); valid when DONE=1.
REQ-010 DONE  out  1  SHALL be high only in state SHOW.

Function
REQ-011 Each KEY bit SHALL pass through SYNC_STAGES flip-flops; a press SHALL be a one-cycle pulse on a synchronized 1->0 transition.
REQ-012 The FSM SHALL have four states: LOAD_A, LOAD_B, CALC, SHOW.
REQ-013 In LOAD_A, an enter pulse SHALL capture SW into A and move to LOAD_B.
REQ-014 In LOAD_B, an enter pulse SHALL capture SW into B, clear the borrow register and bit counter, and move to CALC.
REQ-015 CALC SHALL compute one difference bit per cycle, LSB first, with ripple borrow: d=a^b^br, br'=(~a&b)|(~(a^b)&br).
REQ-016 CALC SHALL last exactly WIDTH cycles, then move to SHOW; DONE SHALL rise WIDTH+1 edges after the B-capture edge.
REQ-017 Enter pulses during CALC SHALL be ignored.
REQ-018 In SHOW, an enter pulse SHALL capture SW into A and move to LOAD_B (chained operation).
REQ-019 A clear pulse in any state SHALL zero A, B, result and borrow and move to LOAD_A on the same edge.
REQ-020 Simultaneous enter and clear pulses SHALL resolve as clear.
REQ-021 LED SHALL be 0 in LOAD_A and CALC, A in LOAD_B, and the result in SHOW.
REQ-022 Key-press latency SHALL be SYNC_STAGES+1 rising edges from the KEY falling edge to the state change.
REQ-023 Subtraction SHALL wrap modulo 2^WIDTH.

Reset
REQ-024 RST high SHALL asynchronously force: state LOAD_A, A=B=result=0, borrow=0, counter=0, synchronizer flops=1 (released), LED=0, BORROW=0, DONE=0.
REQ-025 RST asserted mid-CALC SHALL abort the operation; no partial result SHALL survive.

Configuration
REQ-026 With macro CALC_SUB_ABS_DISPLAY_EN defined, the SHOW result SHALL be |A-B|, i.e. the two's-complement negation of the raw difference when BORROW=1; BORROW is unchanged.
REQ-027 Without CALC_SUB_ABS_DISPLAY_EN, the SHOW result SHALL be the raw modulo-2^WIDTH difference, and no negation logic SHALL be built.

Structure
REQ-028 Package calc_pkg SHALL hold the FSM state typedef (calc_state_t) and the WIDTH default constant.
REQ-029 Sub-module key_sync_edge (synchronizer plus falling-edge pulse) SHALL be instantiated once per KEY bit.

Verification
REQ-030 RST pulse, then A=9, B=3 entered -> after WIDTH+1 cycles: DONE=1, LED=0110, BORROW=0.
REQ-031 A=3, B=9 -> BORROW=1; LED=1010 without the macro, LED=0110 with CALC_SUB_ABS_DISPLAY_EN.
REQ-032 A=0, B=0 -> LED=0000, BORROW=0; A=15, B=15 -> LED=0000, BORROW=0.
REQ-033 Clear pressed on CALC cycle 2 -> next edge: state LOAD_A, LED=0, DONE=0; an enter pressed during CALC is ignored (result unchanged).
REQ-034 Enter and clear falling on the same edge while in LOAD_B -> LOAD_A, A=0.
REQ-035 RST asserted asynchronously mid-CALC, between clock edges -> outputs are 0 immediately; a later A=5, B=2 sequence gives LED=0011.
